// File: rtl/spi_receiver.sv
// SPI slave receiver: 2-flop line sync, sck edge detect, MSB-first deserialiser, one-word output buffer; optional frame_err via SPI_RX_FRAME_ERR_EN.
// Latency: rx_valid rises 3 clk after the pin-level sampling edge of a word's last bit.
// Backpressure: one-word buffer; a word completing while rx_valid=1 and rx_ready=0 is dropped and overflow pulses.
module spi_receiver #(
  parameter int   p_data_width  = 8,
  parameter logic p_cs_polar    = 1'b1,
  parameter logic p_sample_rise = 1'b1,
  parameter logic p_sck_idle    = 1'b1
) (
  input  logic                    clk,
  input  logic                    s_rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic [p_data_width-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    overflow,
  output logic                    busy
`ifdef SPI_RX_FRAME_ERR_EN
  ,
  output logic                    frame_err
`endif
);

  localparam int CW = $clog2(p_data_width);
  localparam logic [CW-1:0] LAST = CW'(p_data_width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic sck_m, sck_s, sck_d;
  logic cs_m, cs_s;
  logic mosi_m, mosi_s;
  logic samp, cs_act;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [p_data_width-1:0] shift_q, shift_d;
  logic [p_data_width-1:0] word;
  logic                    done;
  logic [p_data_width-1:0] dat_d;
  logic                    vld_d, ovf_d;
`ifdef SPI_RX_FRAME_ERR_EN
  logic                    ferr_q, ferr_d;
`endif

  always_ff @(posedge clk) begin
    if (s_rst) begin
      sck_m  <= p_sck_idle;
      sck_s  <= p_sck_idle;
      sck_d  <= p_sck_idle;
      cs_m   <= p_cs_polar;
      cs_s   <= p_cs_polar;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sck_m  <= sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      cs_m   <= cs_n;
      cs_s   <= cs_m;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  assign samp   = p_sample_rise ? (sck_s & ~sck_d) : (~sck_s & sck_d);
  assign cs_act = (cs_s != p_cs_polar);
  assign word   = {shift_q[p_data_width-2:0], mosi_s};
  assign busy   = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done    = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
    ferr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cs_act) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        // cs release outranks a coincident sample
        if (!cs_act) begin
          state_d = IDLE;
`ifdef SPI_RX_FRAME_ERR_EN
          ferr_d  = (cnt_q != '0);
`endif
        end else if (samp) begin
          shift_d = word;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            done  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dat_d = rx_data;
    vld_d = rx_valid;
    ovf_d = 1'b0;
    if (done) begin
      if (!rx_valid || rx_ready) begin
        dat_d = word;
        vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
      ferr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      rx_data  <= dat_d;
      rx_valid <= vld_d;
      overflow <= ovf_d;
`ifdef SPI_RX_FRAME_ERR_EN
      ferr_q   <= ferr_d;
`endif
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  assign frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: mode-3 style master (sck idles high, sample on rise), 8-clk sck period.
module tb_spi_receiver;

  logic       clk = 1'b0;
  logic       s_rst, sck, cs_n, mosi, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, overflow, busy;
`ifdef SPI_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] acc_q[$];
  int         ovf_cnt = 0;
  int         ferr_cnt = 0;

  spi_receiver dut (
    .clk      (clk),
    .s_rst    (s_rst),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overflow (overflow),
    .busy     (busy)
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Passive monitor: record accepted words and pulse counts
  always @(negedge clk) begin
    if (!s_rst) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (overflow) ovf_cnt++;
`ifdef SPI_RX_FRAME_ERR_EN
      if (frame_err) ferr_cnt++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sck  = 1'b0;
      mosi = w[7-i];
      repeat (4) tick();
      sck = 1'b1;
      repeat (4) tick();
    end
  endtask

  task automatic cs_on();
    cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic cs_off();
    cs_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    s_rst = 1'b1; sck = 1'b1; cs_n = 1'b1; mosi = 1'b0; rx_ready = 1'b0;
    repeat (3) tick();
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    s_rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int base = acc_q.size();
    int ob = ovf_cnt;
    rx_ready = 1'b1;
    cs_on();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    send_bits(8'hA5, 8);
    cs_off();
    n_vec++; if (acc_q.size() !== base + 1) begin n_err++; $display("FAIL single_count: got %0d want %0d", acc_q.size(), base + 1); end
    else begin
      n_vec++; if (acc_q[base] !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", acc_q[base]); end
    end
    n_vec++; if (ovf_cnt !== ob) begin n_err++; $display("FAIL single_ovf: got %0d want %0d", ovf_cnt, ob); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL single_valid: got %b want 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int base = acc_q.size();
    rx_ready = 1'b1;
    cs_on();
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    cs_off();
    n_vec++; if (acc_q.size() !== base + 2) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", acc_q.size(), base + 2); end
    else begin
      n_vec++; if (acc_q[base] !== 8'h3C) begin n_err++; $display("FAIL b2b_first: got %h want 3c", acc_q[base]); end
      n_vec++; if (acc_q[base+1] !== 8'hC3) begin n_err++; $display("FAIL b2b_second: got %h want c3", acc_q[base+1]); end
    end
  endtask

  task automatic test_overflow();
    int ob = ovf_cnt;
    rx_ready = 1'b0;
    cs_on();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    cs_off();
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", rx_valid); end
    n_vec++; if (rx_data !== 8'h11) begin n_err++; $display("FAIL ovf_data: got %h want 11", rx_data); end
    n_vec++; if (ovf_cnt - ob !== 1) begin n_err++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - ob); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got %b want 0", rx_valid); end
    n_vec++; if (rx_data !== 8'h11) begin n_err++; $display("FAIL ovf_hold: got %h want 11", rx_data); end
    n_vec++; if (acc_q[$] !== 8'h11) begin n_err++; $display("FAIL ovf_consumed: got %h want 11", acc_q[$]); end
  endtask

  task automatic test_coincident();
    int ob = ovf_cnt;
    rx_ready = 1'b0;
    cs_on();
    send_bits(8'h55, 8);
    send_bits(8'hAA, 7);
    sck  = 1'b0;
    mosi = 1'b0;
    repeat (4) tick();
    n_vec++; if (rx_data !== 8'h55 || rx_valid !== 1'b1) begin n_err++; $display("FAIL coin_pre: got %h/%b want 55/1", rx_data, rx_valid); end
    sck = 1'b1;
    // completion lands on the third edge after the pin rise
    tick();
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL coin_valid: got %b want 1", rx_valid); end
    n_vec++; if (rx_data !== 8'hAA) begin n_err++; $display("FAIL coin_data: got %h want aa", rx_data); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL coin_ovf: got %b want 0", overflow); end
    tick();
    cs_off();
    n_vec++; if (ovf_cnt !== ob) begin n_err++; $display("FAIL coin_ovf_total: got %0d want %0d", ovf_cnt, ob); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_partial();
    int base = acc_q.size();
    int fb = ferr_cnt;
    rx_ready = 1'b1;
    cs_on();
    send_bits(8'hFF, 5);
    cs_off();
    n_vec++; if (acc_q.size() !== base) begin n_err++; $display("FAIL partial_drop: got %0d want %0d", acc_q.size(), base); end
`ifdef SPI_RX_FRAME_ERR_EN
    n_vec++; if (ferr_cnt - fb !== 1) begin n_err++; $display("FAIL partial_ferr: got %0d want 1", ferr_cnt - fb); end
`endif
    cs_on();
    send_bits(8'h0F, 8);
    cs_off();
    n_vec++; if (acc_q.size() !== base + 1) begin n_err++; $display("FAIL partial_count: got %0d want %0d", acc_q.size(), base + 1); end
    else begin
      n_vec++; if (acc_q[base] !== 8'h0F) begin n_err++; $display("FAIL partial_data: got %h want 0f", acc_q[base]); end
    end
    n_vec++; if (ferr_cnt - fb > 1) begin n_err++; $display("FAIL partial_ferr_total: got %0d want <=1", ferr_cnt - fb); end
  endtask

  task automatic test_reset_mid();
    int base;
    rx_ready = 1'b0;
    cs_on();
    send_bits(8'h5A, 8);
    send_bits(8'hF0, 4);
    n_vec++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got %h/%b want 5a/1", rx_data, rx_valid); end
    s_rst = 1'b1;
    tick();
    tick();
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", rx_valid); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h want 00", rx_data); end
    n_vec++; if (busy !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL rmid_busy_ovf: got %b/%b want 0/0", busy, overflow); end
    s_rst = 1'b0;
    rx_ready = 1'b1;
    tick();
    cs_off();
    base = acc_q.size();
    cs_on();
    send_bits(8'h81, 8);
    cs_off();
    n_vec++; if (acc_q.size() !== base + 1) begin n_err++; $display("FAIL rmid_count: got %0d want %0d", acc_q.size(), base + 1); end
    else begin
      n_vec++; if (acc_q[base] !== 8'h81) begin n_err++; $display("FAIL rmid_data_after: got %h want 81", acc_q[base]); end
    end
    n_vec++; if (rx_data !== 8'h81) begin n_err++; $display("FAIL rmid_rx_data: got %h want 81", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_coincident();
    test_partial();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
